// File: rtl/boot_loader_pkg.sv
// Shared constants for the instruction-memory boot loader: FSM encoding and
// header layout.
package boot_loader_pkg;

    localparam logic [2:0] ST_HDR_HI = 3'd0;
    localparam logic [2:0] ST_HDR_LO = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_RUN    = 3'd4;
    localparam logic [2:0] ST_ERR    = 3'd5;

    // Header is a 16-bit big-endian word count.
    localparam int HDR_BYTES = 2;

endpackage

// File: rtl/byte_to_word_packer.sv
// Assembles big-endian 32-bit words from accepted bytes and emits a one-cycle
// word_valid pulse the cycle after the fourth byte of each word.
module byte_to_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic        last_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] shift_q, shift_d;
    logic        vld_q;

    assign last_o       = accept_i && (cnt_q == 2'd3);
    assign word_valid_o = vld_q;
    // The completed word stays in the shift register for the pulse cycle;
    // the next byte only overwrites it at the end of that cycle.
    assign word_o       = shift_q;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (accept_i) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {shift_q[23:0], byte_i};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            shift_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            vld_q   <= last_o;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed byte image into instruction memory, holding the CPU
// in reset until the image is written and a short hold interval has elapsed.
module imem_boot_loader
    import boot_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int RESET_HOLD = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;
    localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);

    logic [2:0]            state_q, state_d;
    logic [7:0]            hdr_q, hdr_d;
    logic [15:0]           n_q, n_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [HW-1:0]         hold_q, hold_d;

    logic        accept, pk_last, pk_vld, last_word;
    logic [31:0] pk_word;
    logic [16:0] n_hdr;

    assign in_ready  = !reset && (state_q == ST_HDR_HI || state_q == ST_HDR_LO ||
                                  state_q == ST_DATA);
    assign accept    = in_valid && in_ready;
    assign n_hdr     = {1'b0, hdr_q, in_data};
    // Count is one bit wider than the address so N == depth never wraps.
    assign last_word = (17'(cnt_q) + 17'd1) == {1'b0, n_q};

    byte_to_word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .accept_i     (accept && state_q == ST_DATA),
        .byte_i       (in_data),
        .last_o       (pk_last),
        .word_valid_o (pk_vld),
        .word_o       (pk_word)
    );

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        hold_d  = hold_q;
        case (state_q)
            ST_HDR_HI: if (accept) begin
                hdr_d   = in_data;
                state_d = ST_HDR_LO;
            end
            ST_HDR_LO: if (accept) begin
                n_d    = n_hdr[15:0];
                hold_d = '0;
                if (n_hdr > DEPTH)       state_d = ST_ERR;
                else if (n_hdr == 17'd0) state_d = ST_HOLD;
                else                     state_d = ST_DATA;
            end
            ST_DATA: if (pk_last) begin
                addr_d = cnt_q[ADDR_WIDTH-1:0];
                cnt_d  = cnt_q + 1'b1;
                if (last_word) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HOLD_LAST) state_d = ST_RUN;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_HDR_HI;
            hdr_q   <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            hold_q  <= hold_d;
        end
    end

    // Outputs are forced to their idle values while reset is asserted, so a
    // write registered just before reset never reaches memory.
    assign imem_we      = pk_vld && !reset;
    assign imem_addr    = reset ? '0 : addr_q;
    assign imem_wdata   = reset ? '0 : pk_word;
    assign cpu_reset    = reset || (state_q != ST_RUN);
    assign done         = !reset && (state_q == ST_RUN);
    assign error        = !reset && (state_q == ST_ERR);
    assign words_loaded = reset ? '0 : cnt_q;

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Hardware counterpart of the bench-side memory-image load: receives a program image as a byte stream and writes it into CPU instruction memory through a 32-bit write port.
- Holds the CPU in reset until the image is complete, then releases it.
- Sits between an external byte source (UART/debug link) and the instruction-memory write port; its cpu_reset output drives the CPU core's reset input.

Parameters:
- ADDR_WIDTH, 10, instruction-memory word-address width; depth = 2**ADDR_WIDTH words.
- RESET_HOLD, 4, number of cycles cpu_reset stays high after the last write; legal range is 1 or more.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  byte source has a valid byte.
- in_data  input  8  byte payload.
- in_ready  output  1  loader accepts a byte; a transfer occurs when in_valid && in_ready at a rising edge.
- imem_we  output  1  one-cycle instruction-memory write strobe.
- imem_addr  output  ADDR_WIDTH  word address for the write.
- imem_wdata  output  32  word for the write.
- cpu_reset  output  1  reset to the CPU core, active-high.
- done  output  1  image loaded and CPU released.
- error  output  1  header word count exceeds memory depth (sticky).
- words_loaded  output  ADDR_WIDTH+1  count of words written so far.

Behaviour:
- Stream format: 16-bit word count N, MSB byte first, followed by N words of 4 bytes each, MSB byte first. Word i is written to address i.
- FSM states: HDR_HI, HDR_LO, DATA, HOLD, RUN, ERR. The state after reset is HDR_HI.
- Values while reset is high and on the first cycle after it: in_ready=0 during reset, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, done=0, error=0, words_loaded=0.
- in_ready is decoded from the state: it is 1 in HDR_HI, HDR_LO and DATA, and 0 in HOLD, RUN and ERR. A source that keeps in_valid high can therefore transfer one byte per cycle.
- HDR_HI: on transfer, latch count[15:8] and go to HDR_LO.
- HDR_LO: on transfer, latch count[7:0], then:
  - if N > 2**ADDR_WIDTH, go to ERR;
  - else if N == 0, go to HOLD;
  - else go to DATA.
- DATA: a 2-bit byte counter and a 32-bit shift register assemble each word (shift left 8, OR in the new byte).
  - On the 4th byte of a word, the write is registered. On the next cycle imem_we=1, imem_addr=word index and imem_wdata=the assembled word, all for exactly one cycle.
  - words_loaded increments in the same cycle as imem_we.
  - Byte acceptance continues uninterrupted during the write cycle, with no bubble.
  - Write latency is exactly 1 cycle after the accepting edge of the 4th byte.
- After the 4th byte of word N-1, go to HOLD. The final imem_we pulse occurs in the first HOLD cycle.
- HOLD: cpu_reset=1 for exactly RESET_HOLD cycles, counted from HOLD entry. Then go to RUN.
- RUN: cpu_reset=0 and done=1. The state is terminal until reset, and incoming bytes are not accepted.
- ERR: error=1, cpu_reset=1, no writes, in_ready=0. The state is terminal until reset.
- in_valid with no in_ready: no state change; in_data is ignored.
- Gaps in in_valid mid-word are allowed. The partial word and the byte counter are held.
- Reset mid-load (any state): return to HDR_HI with all counters cleared and cpu_reset=1. Memory contents already written are not cleared, and no write occurs in the reset cycle.
- N == 2**ADDR_WIDTH is legal and fills the memory exactly. The final address 2**ADDR_WIDTH-1 must not wrap, and words_loaded needs its extra bit to reach 2**ADDR_WIDTH.

Decomposition:
- Shared package (boot_loader_pkg): state encoding constants (3-bit: HDR_HI=0, HDR_LO=1, DATA=2, HOLD=3, RUN=4, ERR=5) and the header byte-count constant (2).
- One natural sub-module: byte_to_word_packer (byte counter plus shift register, outputs a word_valid pulse with the assembled word).
- The FSM, address/word counter and hold counter stay in the top module.

Test Plan:
- Stream 00 02 | 8C 08 00 00 | 20 09 00 01 with in_valid held high:
  - in_ready is high for 10 cycles;
  - writes occur at addr 0 = 0x8C080000 and addr 1 = 0x20090001, each one cycle after its 4th byte;
  - cpu_reset falls exactly 4 cycles after HOLD entry, then done=1 and words_loaded=2.
- Stream 00 00 -> no imem_we; HOLD lasts 4 cycles, then done=1 and words_loaded=0.
- Header 04 01 with ADDR_WIDTH=10 (N=1025) -> error=1 and in_ready=0 from the next cycle; cpu_reset stays 1 for 20 cycles; no writes.
- Stream 00 01 DE AD BE EF with in_valid deasserted 3 cycles between each byte -> exactly one write, addr 0 = 0xDEADBEEF; no spurious strobes.
- Reset asserted after 2 data bytes of word 0 -> after reset: state HDR_HI, cpu_reset=1, words_loaded=0. A full reload 00 01 11 22 33 44 writes 0x11223344 to addr 0.
- ADDR_WIDTH=2, N=4 -> writes to addr 0..3, words_loaded=4, no wrap, done=1. Extra bytes offered after done are not accepted (in_ready=0).
